lgn_argmax: RTL
===============

# lgn_argmax

Downstream stage of the logic-gate-network core. Consumes the 16-bit vote words the network drives out, one word per cycle. Popcounts and accumulates each class's votes over a fixed number of words, then tracks the running maximum across classes. Presents the winning class index and its score on a valid/ready output toward the pad/readout logic.

## Interface
Parameters:
- VOTE_W, 16, vote bits per input word (network output width)
- NUM_CLASSES, 10, classes per frame
- WORDS_PER_CLASS, 4, consecutive words belonging to one class
- SCORE_W, $clog2(VOTE_W*WORDS_PER_CLASS+1) (=7), score width
- CLASS_W, $clog2(NUM_CLASSES) (=4), class index width

Ports (clock, reset first):
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  vote word present
- in_sof  input  1  start of frame; qualified by in_valid
- in_data  input  VOTE_W  vote bits
- in_ready  output  1  block accepts a word this cycle
- out_valid  output  1  result held
- out_ready  input  1  consumer takes result
- out_class  output  CLASS_W  winning class index
- out_score  output  SCORE_W  winning class vote count
- out_margin  output  SCORE_W  winner minus runner-up (LGN_ARGMAX_MARGIN_EN only)

## Operation
- Accept = in_valid && in_ready.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- ACCUM: each accept adds popcount(in_data) to the class accumulator acc. Then word_cnt++.
- When word_cnt wraps at WORDS_PER_CLASS-1, the completed class score (acc + popcount) is compared to best.
  - Replace best only on strictly greater, so ties go to the lowest class index.
  - Class 0 always loads best.
  - acc clears, and class_cnt++.
- The last word of class NUM_CLASSES-1 ends the frame.
  - Final compare result is latched into out_class/out_score.
  - Go to DONE; all counters clear.
- DONE: outputs held stable until out_valid && out_ready, then back to ACCUM.
- in_sof on an accepted word restarts the frame.
  - word_cnt, class_cnt, acc, best are treated as zero.
  - That word counts as word 0 of class 0.
  - An in_sof arriving mid-frame silently discards the partial frame.
- in_sof is ignored in DONE because nothing is accepted.
- Arithmetic:
  - Popcount yields $clog2(VOTE_W+1) bits, zero-extended to SCORE_W.
  - acc cannot overflow by construction.
- Reset (async, any time including mid-frame): state=ACCUM; all counters, acc and best =0.
  - Reset values: out_valid=0, out_class=0, out_score=0, out_margin=0, in_ready=1.

## Timing
- in_ready is a registered state decode; it does not depend combinationally on out_ready.
- Latency: out_valid rises the cycle after the final word is accepted.
- Throughput: one word per cycle in ACCUM.
  - Minimum frame period = NUM_CLASSES*WORDS_PER_CLASS + 1 cycles with out_ready held high.
- in_ready returns high the cycle after the output handshake; there is no bypass.
- out_class/out_score/out_margin change only on the transition into DONE.

## Configuration
- LGN_ARGMAX_MARGIN_EN defined:
  - Also track second-best score, updated on every class completion with tie-aware ordering.
  - A tie for best gives margin 0.
  - out_margin = best − second, latched with out_score.
- Undefined:
  - No second-best register.
  - out_margin port is absent.

## Structure
- Shared package lgn_pkg holds:
  - VOTE_W, NUM_CLASSES, WORDS_PER_CLASS constants.
  - The derived SCORE_W/CLASS_W.
  - The state enum typedef (ACCUM, DONE).
- One sub-module, lgn_popcount: combinational VOTE_W-bit adder-tree popcount, parameterised on width.
- Counters, compare and FSM live in lgn_argmax.

## Test plan
- Class 3 words all 0xFFFF, all others 0x0000, out_ready=1 → out_valid one cycle after word 40; out_class=3, out_score=64, margin=64.
- Classes 2 and 7 each total 20 votes, others 5 → out_class=2 (tie to lower index), out_score=20, margin=0.
- out_ready=0 for 10 cycles after DONE while in_valid=1 → in_ready=0 and no word consumed; outputs stable. After the handshake, the next word is accepted the following cycle.
- in_sof asserted at word 17 of a frame, then 40 more words with class 5 = 0x00FF ×4, others 0x0001 ×4 → single result: out_class=5, out_score=32.
- rst_n pulsed low asynchronously mid-frame (word 25) and in DONE → outputs zero immediately, in_ready=1. A fresh 40-word frame then produces a correct result.
- Back-to-back frames with out_ready=1 and random in_valid gaps → results match a reference model; period ≥41 cycles.

Source files
------------

// File: rtl/lgn_pkg.sv
// Shared constants and types for the logic-gate-network argmax stage.
// Build option: LGN_ARGMAX_MARGIN_EN (see lgn_argmax.sv).
package lgn_pkg;

  localparam int VOTE_W          = 16;
  localparam int NUM_CLASSES     = 10;
  localparam int WORDS_PER_CLASS = 4;

  // Widest possible class score is every vote bit set in every word of a class.
  localparam int SCORE_W = $clog2(VOTE_W * WORDS_PER_CLASS + 1);
  localparam int CLASS_W = $clog2(NUM_CLASSES);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } lgn_state_e;

endpackage

// File: rtl/lgn_popcount.sv
// Combinational population count of a W-bit word built as a binary adder tree.
// Nodes use heap indexing: leaves at [W..2W-1], node i sums children 2i and
// 2i+1, so node 1 holds the total for any W (power of two or not).
module lgn_popcount #(
  parameter int W     = 16,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     data,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] tree_sum(input logic [W-1:0] d);
    logic [CNT_W-1:0] node [2*W];
    node[0] = {CNT_W{1'b0}};
    for (int i = 0; i < W; i++) begin
      node[W + i] = CNT_W'(d[i]);
    end
    for (int i = W - 1; i >= 1; i--) begin
      node[i] = node[2*i] + node[2*i + 1];
    end
    return node[1];
  endfunction

  // Reduce the input word to its set-bit count.
  always_comb begin
    count = tree_sum(data);
  end

endmodule

// File: rtl/lgn_argmax.sv
// Argmax stage behind the logic-gate network: popcounts each vote word,
// accumulates per-class scores, keeps the running best (ties favour the lower
// class index) and hands out the winner on a valid/ready interface.
// Build option: define LGN_ARGMAX_MARGIN_EN to also track the runner-up score
// and expose out_margin = best - second.
module lgn_argmax
  import lgn_pkg::*;
#(
  parameter int VOTE_W          = lgn_pkg::VOTE_W,
  parameter int NUM_CLASSES     = lgn_pkg::NUM_CLASSES,
  parameter int WORDS_PER_CLASS = lgn_pkg::WORDS_PER_CLASS,
  parameter int SCORE_W         = $clog2(VOTE_W * WORDS_PER_CLASS + 1),
  parameter int CLASS_W         = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [VOTE_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic [SCORE_W-1:0] out_score
`ifdef LGN_ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W-1:0] out_margin
`endif
);

  localparam int POP_W  = $clog2(VOTE_W + 1);
  localparam int WORD_W = (WORDS_PER_CLASS > 1) ? $clog2(WORDS_PER_CLASS) : 1;
  localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(WORDS_PER_CLASS - 1);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

  lgn_state_e         state_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [WORD_W-1:0]  word_cnt_r;
  logic [CLASS_W-1:0] class_cnt_r;
  logic [SCORE_W-1:0] acc_r;
  logic [SCORE_W-1:0] best_r;
  logic [CLASS_W-1:0] best_class_r;
  logic [CLASS_W-1:0] out_class_r;
  logic [SCORE_W-1:0] out_score_r;

  logic [POP_W-1:0]   pop_s;
  logic [SCORE_W-1:0] pop_ext_s;
  logic               accept_s;
  logic [WORD_W-1:0]  word_base_s;
  logic [CLASS_W-1:0] class_base_s;
  logic [SCORE_W-1:0] acc_base_s;
  logic [SCORE_W-1:0] best_base_s;
  logic [CLASS_W-1:0] best_class_base_s;
  logic [SCORE_W-1:0] sum_s;
  logic               class_done_s;
  logic               frame_done_s;
  logic               take_s;
  logic [SCORE_W-1:0] new_best_s;
  logic [CLASS_W-1:0] new_class_s;

`ifdef LGN_ARGMAX_MARGIN_EN
  logic [SCORE_W-1:0] second_r;
  logic [SCORE_W-1:0] out_margin_r;
  logic [SCORE_W-1:0] second_base_s;
  logic [SCORE_W-1:0] new_second_s;
`endif

  lgn_popcount #(
    .W     (VOTE_W),
    .CNT_W (POP_W)
  ) u_popcount (
    .data  (in_data),
    .count (pop_s)
  );

  assign pop_ext_s = SCORE_W'(pop_s);

  // Frame bookkeeping for the current word; a start-of-frame word sees zeroed state.
  always_comb begin
    accept_s = in_valid && in_ready_r;
    if (in_sof) begin
      word_base_s       = {WORD_W{1'b0}};
      class_base_s      = {CLASS_W{1'b0}};
      acc_base_s        = {SCORE_W{1'b0}};
      best_base_s       = {SCORE_W{1'b0}};
      best_class_base_s = {CLASS_W{1'b0}};
    end else begin
      word_base_s       = word_cnt_r;
      class_base_s      = class_cnt_r;
      acc_base_s        = acc_r;
      best_base_s       = best_r;
      best_class_base_s = best_class_r;
    end
    sum_s        = acc_base_s + pop_ext_s;
    class_done_s = (word_base_s == LAST_WORD);
    frame_done_s = class_done_s && (class_base_s == LAST_CLASS);
    // Strictly greater keeps the earlier (lower index) class on a tie.
    take_s = (class_base_s == {CLASS_W{1'b0}}) || (sum_s > best_base_s);
    if (take_s) begin
      new_best_s  = sum_s;
      new_class_s = class_base_s;
    end else begin
      new_best_s  = best_base_s;
      new_class_s = best_class_base_s;
    end
  end

`ifdef LGN_ARGMAX_MARGIN_EN
  // Runner-up tracking; a score equal to best becomes second so a tie yields margin 0.
  always_comb begin
    if (in_sof) begin
      second_base_s = {SCORE_W{1'b0}};
    end else begin
      second_base_s = second_r;
    end
    if (class_base_s == {CLASS_W{1'b0}}) begin
      new_second_s = {SCORE_W{1'b0}};
    end else if (sum_s > best_base_s) begin
      new_second_s = best_base_s;
    end else if (sum_s > second_base_s) begin
      new_second_s = sum_s;
    end else begin
      new_second_s = second_base_s;
    end
  end
`endif

  // Control FSM with counters, accumulators and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ACCUM;
      in_ready_r   <= 1'b1;
      out_valid_r  <= 1'b0;
      word_cnt_r   <= {WORD_W{1'b0}};
      class_cnt_r  <= {CLASS_W{1'b0}};
      acc_r        <= {SCORE_W{1'b0}};
      best_r       <= {SCORE_W{1'b0}};
      best_class_r <= {CLASS_W{1'b0}};
      out_class_r  <= {CLASS_W{1'b0}};
      out_score_r  <= {SCORE_W{1'b0}};
`ifdef LGN_ARGMAX_MARGIN_EN
      second_r     <= {SCORE_W{1'b0}};
      out_margin_r <= {SCORE_W{1'b0}};
`endif
    end else begin
      case (state_r)
        ACCUM: begin
          if (accept_s) begin
            if (frame_done_s) begin
              state_r      <= DONE;
              in_ready_r   <= 1'b0;
              out_valid_r  <= 1'b1;
              out_class_r  <= new_class_s;
              out_score_r  <= new_best_s;
              word_cnt_r   <= {WORD_W{1'b0}};
              class_cnt_r  <= {CLASS_W{1'b0}};
              acc_r        <= {SCORE_W{1'b0}};
              best_r       <= {SCORE_W{1'b0}};
              best_class_r <= {CLASS_W{1'b0}};
`ifdef LGN_ARGMAX_MARGIN_EN
              out_margin_r <= new_best_s - new_second_s;
              second_r     <= {SCORE_W{1'b0}};
`endif
            end else if (class_done_s) begin
              word_cnt_r   <= {WORD_W{1'b0}};
              class_cnt_r  <= class_base_s + CLASS_W'(1'b1);
              acc_r        <= {SCORE_W{1'b0}};
              best_r       <= new_best_s;
              best_class_r <= new_class_s;
`ifdef LGN_ARGMAX_MARGIN_EN
              second_r     <= new_second_s;
`endif
            end else begin
              word_cnt_r   <= word_base_s + WORD_W'(1'b1);
              class_cnt_r  <= class_base_s;
              acc_r        <= sum_s;
              best_r       <= best_base_s;
              best_class_r <= best_class_base_s;
`ifdef LGN_ARGMAX_MARGIN_EN
              second_r     <= second_base_s;
`endif
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ACCUM;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_class = out_class_r;
  assign out_score = out_score_r;
`ifdef LGN_ARGMAX_MARGIN_EN
  assign out_margin = out_margin_r;
`endif

endmodule
